// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a five-stage pipeline: load-use stalls,
// taken-branch flushes, data-memory wait/timeout handling and performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             Clk_in,
    input  logic             Rst,
    input  logic             IDEX_MemRead_in,
    input  logic [4:0]       IDEX_Rt_in,
    input  logic [4:0]       IFID_Rs_in,
    input  logic [4:0]       IFID_Rt_in,
    input  logic             EXMEM_Branch_in,
    input  logic             EXMEM_Zero_in,
    input  logic             EXMEM_MemRead_in,
    input  logic             EXMEM_MemWrite_in,
    input  logic             DMem_Ack_in,
    output logic             PCWrite_out,
    output logic             IFID_Write_out,
    output logic             PCSrc_out,
    output logic             IFID_Flush_out,
    output logic             IDEX_Flush_out,
    output logic             EXMEM_Flush_out,
    output logic             Pipe_Hold_out,
    output logic             MEMWB_Bubble_out,
    output logic             DMem_Req_out,
    output logic [1:0]       State_out,
    output logic [CNT_W-1:0] StallCount_out,
    output logic [CNT_W-1:0] FlushCount_out,
    output logic             Timeout_out
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t           state_q, state_nxt;
    logic [7:0]       wait_cnt_q, wait_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             timeout_q;

    logic mem, luh, br;
    logic resolve, luh_en;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mem = EXMEM_MemRead_in | EXMEM_MemWrite_in;
    assign br  = EXMEM_Branch_in & EXMEM_Zero_in;
    assign luh = IDEX_MemRead_in & (IDEX_Rt_in != 5'd0) &
                 ((IDEX_Rt_in == IFID_Rs_in) | (IDEX_Rt_in == IFID_Rt_in));

    always_comb begin
        PCWrite_out      = 1'b1;
        IFID_Write_out   = 1'b1;
        PCSrc_out        = 1'b0;
        IFID_Flush_out   = 1'b0;
        IDEX_Flush_out   = 1'b0;
        EXMEM_Flush_out  = 1'b0;
        Pipe_Hold_out    = 1'b0;
        MEMWB_Bubble_out = 1'b0;
        DMem_Req_out     = 1'b0;
        state_nxt        = state_q;
        wait_cnt_nxt     = wait_cnt_q;
        resolve          = 1'b0;
        luh_en           = 1'b0;

        if (Rst) begin
            PCWrite_out    = 1'b0;
            IFID_Write_out = 1'b0;
            state_nxt      = ST_RUN;
            wait_cnt_nxt   = 8'd0;
        end else begin
            case (state_q)
                ST_RUN, ST_FLUSH: begin
                    if (mem && !DMem_Ack_in) begin
                        DMem_Req_out     = 1'b1;
                        Pipe_Hold_out    = 1'b1;
                        PCWrite_out      = 1'b0;
                        IFID_Write_out   = 1'b0;
                        MEMWB_Bubble_out = 1'b1;
                        state_nxt        = ST_MEM_WAIT;
                        wait_cnt_nxt     = 8'd1;
                    end else begin
                        resolve      = 1'b1;
                        luh_en       = (state_q == ST_RUN);
                        DMem_Req_out = mem;
                    end
                end
                ST_MEM_WAIT: begin
                    if (DMem_Ack_in) begin
                        // The held access completes now; the rest of the cycle
                        // behaves like an ordinary RUN cycle.
                        resolve      = 1'b1;
                        luh_en       = 1'b1;
                        DMem_Req_out = 1'b1;
                    end else begin
                        DMem_Req_out     = 1'b1;
                        Pipe_Hold_out    = 1'b1;
                        PCWrite_out      = 1'b0;
                        IFID_Write_out   = 1'b0;
                        MEMWB_Bubble_out = 1'b1;
                        if (wait_cnt_q == TIMEOUT_C) begin
                            state_nxt = ST_ERROR;
                        end else begin
                            wait_cnt_nxt = wait_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    Pipe_Hold_out    = 1'b1;
                    PCWrite_out      = 1'b0;
                    IFID_Write_out   = 1'b0;
                    MEMWB_Bubble_out = 1'b1;
                end
            endcase

            if (resolve) begin
                wait_cnt_nxt = 8'd0;
                state_nxt    = ST_RUN;
                if (br) begin
                    PCSrc_out       = 1'b1;
                    IFID_Flush_out  = 1'b1;
                    IDEX_Flush_out  = 1'b1;
                    EXMEM_Flush_out = 1'b1;
                    state_nxt       = ST_FLUSH;
                end else if (luh && luh_en) begin
                    PCWrite_out    = 1'b0;
                    IFID_Write_out = 1'b0;
                    IDEX_Flush_out = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            wait_cnt_q <= wait_cnt_nxt;
            if (!PCWrite_out && (state_q != ST_ERROR)) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
            if (PCSrc_out) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
            if (state_nxt == ST_ERROR) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign State_out      = state_q;
    assign StallCount_out = stall_cnt_q;
    assign FlushCount_out = flush_cnt_q;
    assign Timeout_out    = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    logic       Clk_in = 1'b0;
    logic       Rst;
    logic       IDEX_MemRead_in;
    logic [4:0] IDEX_Rt_in, IFID_Rs_in, IFID_Rt_in;
    logic       EXMEM_Branch_in, EXMEM_Zero_in;
    logic       EXMEM_MemRead_in, EXMEM_MemWrite_in;
    logic       DMem_Ack_in;
    logic       PCWrite_out, IFID_Write_out, PCSrc_out;
    logic       IFID_Flush_out, IDEX_Flush_out, EXMEM_Flush_out;
    logic       Pipe_Hold_out, MEMWB_Bubble_out, DMem_Req_out;
    logic [1:0] State_out;
    logic [3:0] StallCount_out, FlushCount_out;
    logic       Timeout_out;
    logic [8:0] ctrl;

    int total = 0;
    int bad   = 0;

    // {PCWrite, IFID_Write, PCSrc, IFID_Flush, IDEX_Flush, EXMEM_Flush, Hold, Bubble, Req}
    localparam logic [8:0] C_ZERO = 9'b000000000;
    localparam logic [8:0] C_IDLE = 9'b110000000;
    localparam logic [8:0] C_LUH  = 9'b000010000;
    localparam logic [8:0] C_BR   = 9'b111111000;
    localparam logic [8:0] C_HOLD = 9'b000000111;
    localparam logic [8:0] C_ACK  = 9'b110000001;
    localparam logic [8:0] C_BRAK = 9'b111111001;
    localparam logic [8:0] C_ERR  = 9'b000000110;

    assign ctrl = {PCWrite_out, IFID_Write_out, PCSrc_out, IFID_Flush_out, IDEX_Flush_out,
                   EXMEM_Flush_out, Pipe_Hold_out, MEMWB_Bubble_out, DMem_Req_out};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .Clk_in(Clk_in), .Rst(Rst),
        .IDEX_MemRead_in(IDEX_MemRead_in), .IDEX_Rt_in(IDEX_Rt_in),
        .IFID_Rs_in(IFID_Rs_in), .IFID_Rt_in(IFID_Rt_in),
        .EXMEM_Branch_in(EXMEM_Branch_in), .EXMEM_Zero_in(EXMEM_Zero_in),
        .EXMEM_MemRead_in(EXMEM_MemRead_in), .EXMEM_MemWrite_in(EXMEM_MemWrite_in),
        .DMem_Ack_in(DMem_Ack_in),
        .PCWrite_out(PCWrite_out), .IFID_Write_out(IFID_Write_out), .PCSrc_out(PCSrc_out),
        .IFID_Flush_out(IFID_Flush_out), .IDEX_Flush_out(IDEX_Flush_out),
        .EXMEM_Flush_out(EXMEM_Flush_out), .Pipe_Hold_out(Pipe_Hold_out),
        .MEMWB_Bubble_out(MEMWB_Bubble_out), .DMem_Req_out(DMem_Req_out),
        .State_out(State_out), .StallCount_out(StallCount_out),
        .FlushCount_out(FlushCount_out), .Timeout_out(Timeout_out)
    );

    always #5 Clk_in = ~Clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic clr_in();
        IDEX_MemRead_in = 0; IDEX_Rt_in = 0; IFID_Rs_in = 0; IFID_Rt_in = 0;
        EXMEM_Branch_in = 0; EXMEM_Zero_in = 0;
        EXMEM_MemRead_in = 0; EXMEM_MemWrite_in = 0; DMem_Ack_in = 0;
    endtask

    task automatic set_luh(input logic [4:0] rt);
        IDEX_MemRead_in = 1; IDEX_Rt_in = rt; IFID_Rs_in = rt; IFID_Rt_in = 5'd3;
    endtask

    initial begin
        Rst = 1;
        clr_in();
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(C_ZERO));
        tick();
        chk("rst_state", 32'(State_out), 0);
        chk("rst_stall", 32'(StallCount_out), 0);
        chk("rst_flush", 32'(FlushCount_out), 0);
        chk("rst_tmo", 32'(Timeout_out), 0);
        Rst = 0;
        #1;
        chk("idle_ctrl", 32'(ctrl), 32'(C_IDLE));

        // Load-use stall
        set_luh(5'd5);
        #1;
        chk("luh_ctrl", 32'(ctrl), 32'(C_LUH));
        tick();
        chk("luh_state", 32'(State_out), 0);
        chk("luh_stall", 32'(StallCount_out), 1);
        set_luh(5'd0);
        #1;
        chk("luh_r0_ctrl", 32'(ctrl), 32'(C_IDLE));
        tick();
        chk("luh_r0_stall", 32'(StallCount_out), 1);
        clr_in();

        // Taken branch, then masked load-use in FLUSH
        EXMEM_Branch_in = 1; EXMEM_Zero_in = 1;
        #1;
        chk("br_ctrl", 32'(ctrl), 32'(C_BR));
        tick();
        chk("br_state", 32'(State_out), 2);
        chk("br_flushcnt", 32'(FlushCount_out), 1);
        clr_in();
        IDEX_MemRead_in = 1; IDEX_Rt_in = 5'd7; IFID_Rt_in = 5'd7;
        #1;
        chk("flush_mask_ctrl", 32'(ctrl), 32'(C_IDLE));
        tick();
        chk("flush_ret_state", 32'(State_out), 0);
        chk("flush_mask_stall", 32'(StallCount_out), 1);
        clr_in();

        // Memory access acked 3 cycles after request
        EXMEM_MemRead_in = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("memw_ctrl", 32'(ctrl), 32'(C_HOLD));
            tick();
            chk("memw_state", 32'(State_out), 1);
        end
        DMem_Ack_in = 1;
        #1;
        chk("memw_ack_ctrl", 32'(ctrl), 32'(C_ACK));
        tick();
        chk("memw_done_state", 32'(State_out), 0);
        chk("memw_stall", 32'(StallCount_out), 4);
        clr_in();

        // Timeout: never acked
        EXMEM_MemWrite_in = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tmo_hold_ctrl", 32'(ctrl), 32'(C_HOLD));
            tick();
            chk("tmo_wait_state", 32'(State_out), 1);
            chk("tmo_flag_low", 32'(Timeout_out), 0);
        end
        #1;
        chk("tmo_hold_last", 32'(ctrl), 32'(C_HOLD));
        tick();
        chk("tmo_state", 32'(State_out), 3);
        chk("tmo_flag", 32'(Timeout_out), 1);
        chk("tmo_stall", 32'(StallCount_out), 9);
        chk("err_ctrl", 32'(ctrl), 32'(C_ERR));
        tick();
        chk("err_stay", 32'(State_out), 3);
        chk("err_flag_sticky", 32'(Timeout_out), 1);
        chk("err_stall_frozen", 32'(StallCount_out), 9);
        Rst = 1;
        #1;
        chk("err_rst_ctrl", 32'(ctrl), 32'(C_ZERO));
        tick();
        chk("err_rst_state", 32'(State_out), 0);
        chk("err_rst_flag", 32'(Timeout_out), 0);
        chk("err_rst_stall", 32'(StallCount_out), 0);
        chk("err_rst_flush", 32'(FlushCount_out), 0);
        Rst = 0;
        clr_in();

        // Unacked mem with branch: hold wins; branch taken on the ack cycle
        EXMEM_MemRead_in = 1; EXMEM_Branch_in = 1; EXMEM_Zero_in = 1;
        #1;
        chk("prio_hold_ctrl", 32'(ctrl), 32'(C_HOLD));
        tick();
        chk("prio_wait_state", 32'(State_out), 1);
        DMem_Ack_in = 1;
        #1;
        chk("prio_ack_ctrl", 32'(ctrl), 32'(C_BRAK));
        tick();
        chk("prio_flush_state", 32'(State_out), 2);
        chk("prio_flushcnt", 32'(FlushCount_out), 1);
        chk("prio_stall", 32'(StallCount_out), 1);
        clr_in();
        tick();
        chk("prio_run_state", 32'(State_out), 0);

        // Reset in the middle of MEM_WAIT
        EXMEM_MemRead_in = 1;
        tick();
        tick();
        chk("midw_state", 32'(State_out), 1);
        Rst = 1;
        #1;
        chk("midw_rst_ctrl", 32'(ctrl), 32'(C_ZERO));
        tick();
        chk("midw_rst_state", 32'(State_out), 0);
        chk("midw_rst_stall", 32'(StallCount_out), 0);
        chk("midw_rst_flush", 32'(FlushCount_out), 0);
        Rst = 0;
        clr_in();
        #1;
        chk("midw_idle_ctrl", 32'(ctrl), 32'(C_IDLE));

        // Saturation: 20 consecutive load-use stalls
        set_luh(5'd9);
        for (int i = 1; i <= 20; i++) begin
            #1;
            chk("sat_ctrl", 32'(ctrl), 32'(C_LUH));
            tick();
            chk("sat_stall", 32'(StallCount_out), (i > 15) ? 15 : i);
        end
        chk("sat_state", 32'(State_out), 0);
        clr_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
